// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control FSM of the accumulator CPU.
// Optional single-step mode: define SINGLE_STEP_EN.
//
// Ports:
//   clock       system clock, all state changes on its rising edge
//   reset       synchronous, active-low
//   opcode      instruction opcode, captured at the end of FETCH
//   ac_zero     accumulator == 8'h00
//   dm_ack      data memory write complete
//   step        single-step request (SINGLE_STEP_EN builds only)
//   ld_ac       accumulator load strobe
//   ac_src      accumulator source: 1 = memory data, 0 = ALU
//   pc_src      PC source: 1 = instruction operand, 0 = PC+1
//   pc_ld       PC load strobe (one per retired instruction)
//   dm_we       data memory write enable
//   halted      FSM parked in HALT
//   err         store timed out waiting for dm_ack
//   state       current state code for the LEDs
//   instr_count retired instruction counter, wraps at 8'hFF
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       ac_zero,
  input  logic       dm_ack,
  input  logic       step,
  output logic       ld_ac,
  output logic       ac_src,
  output logic       pc_src,
  output logic       pc_ld,
  output logic       dm_we,
  output logic       halted,
  output logic       err,
  output logic [2:0] state,
  output logic [7:0] instr_count
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Store timeout: WAIT cycles 1..15 map to waitCnt 0..14.
  localparam logic [3:0] WAIT_LAST = 4'd14;

  logic [3:0] opq;
  logic [3:0] waitCnt;
  logic       acZeroQ;
  logic       dmAckQ;
  logic       fetchGo;
  logic       isLda;
  logic       isSta;
  logic       isAlu;
  logic       isJmp;
  logic       isJz;
  logic       isHlt;

`ifdef SINGLE_STEP_EN
  logic stepQ;

  // stepQ resets high so a step held through reset is not a request.
  always_ff @(posedge clock) begin
    if (!reset) stepQ <= 1'b1;
    else        stepQ <= step;
  end

  assign fetchGo = !stepQ && step;
`else
  logic unusedStep;

  assign unusedStep = step;
  assign fetchGo    = 1'b1;
`endif

  assign isLda = opq == OP_LDA;
  assign isSta = opq == OP_STA;
  assign isAlu = (opq >= 4'h3) && (opq <= 4'h7);
  assign isJmp = opq == OP_JMP;
  assign isJz  = opq == OP_JZ;
  assign isHlt = opq == OP_HLT;

  assign halted = state == HALT;

  // Inputs are captured on the edge opening a cycle, so every
  // output is decoded from flops only and stays flat between edges.
  always_comb begin
    ld_ac  = 1'b0;
    ac_src = 1'b0;
    pc_src = 1'b0;
    pc_ld  = 1'b0;
    dm_we  = 1'b0;
    unique case (1'b1)
      state == EXEC: begin
        unique case (1'b1)
          isHlt: ;
          isSta: begin
            dm_we = 1'b1;
            pc_ld = dmAckQ;
          end
          isJmp: begin
            pc_ld  = 1'b1;
            pc_src = 1'b1;
          end
          isJz: begin
            pc_ld  = 1'b1;
            pc_src = acZeroQ;
          end
          default: begin
            pc_ld  = 1'b1;
            ld_ac  = isLda || isAlu;
            ac_src = isLda;
          end
        endcase
      end
      state == WAIT: begin
        dm_we = 1'b1;
        pc_ld = dmAckQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FETCH;
      opq         <= '0;
      waitCnt     <= '0;
      instr_count <= '0;
      err         <= 1'b0;
      acZeroQ     <= 1'b0;
      dmAckQ      <= 1'b0;
    end else begin
      acZeroQ <= ac_zero;
      dmAckQ  <= dm_ack;
      if (pc_ld || (state == EXEC && isHlt))
        instr_count <= instr_count + 8'd1;
      unique case (1'b1)
        state == FETCH: begin
          if (fetchGo) begin
            opq   <= opcode;
            state <= DECODE;
          end
        end
        state == DECODE: state <= EXEC;
        state == EXEC: begin
          waitCnt <= '0;
          if (isHlt)                 state <= HALT;
          else if (isSta && !dmAckQ) state <= WAIT;
          else                       state <= FETCH;
        end
        state == WAIT: begin
          if (dmAckQ) begin
            state <= FETCH;
          end else if (waitCnt == WAIT_LAST) begin
            state <= HALT;
            err   <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        state == HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: opcode  input  4  instruction opcode from the datapath, valid while the instruction memory output is stable.
REQ-004 SHALL have port: ac_zero  input  1  high when the accumulator equals 8'h00.
REQ-005 SHALL have port: dm_ack  input  1  data memory write complete.
REQ-006 SHALL have port: step  input  1  single-step request; used only per REQ-026.
REQ-007 SHALL have outputs, all 1 bit: ld_ac (accumulator load), ac_src (1 = memory data, 0 = ALU result), pc_src (1 = instruction operand, 0 = PC+1), pc_ld (PC load), dm_we (data memory write enable), halted, err.
REQ-008 SHALL have port: state  output  3  current FSM state code for LED display.
REQ-009 SHALL have port: instr_count  output  8  count of retired instructions.

Function
REQ-010 SHALL implement FSM states FETCH=3'd0, DECODE=3'd1, EXEC=3'd2, WAIT=3'd3, HALT=3'd4.
REQ-011 SHALL latch opcode into an internal 4-bit register opq at the end of the FETCH cycle; DECODE and EXEC SHALL use only opq.
REQ-012 SHALL use this opcode map: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 9 JMP, A JZ, F HLT; 8, B-E execute as NOP.
REQ-013 SHALL transition FETCH->DECODE unconditionally (subject to REQ-026), and DECODE->EXEC unconditionally.
REQ-014 In EXEC, LDA SHALL assert ld_ac=1 and ac_src=1; opcodes 3-7 SHALL assert ld_ac=1 and ac_src=0; each for exactly one cycle.
REQ-015 In EXEC, JMP SHALL assert pc_ld=1 with pc_src=1; JZ SHALL assert pc_src=ac_zero as sampled in that EXEC cycle; all other non-HLT, non-STA opcodes SHALL assert pc_ld=1 with pc_src=0.
REQ-016 A non-STA, non-HLT instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXEC), after which the FSM returns to FETCH.
REQ-017 STA SHALL assert dm_we in EXEC; if dm_ack=1 in that cycle, pc_ld=1 (pc_src=0) in the same cycle and the FSM goes to FETCH; otherwise the FSM goes to WAIT.
REQ-018 In WAIT, dm_we SHALL stay 1; on the first cycle with dm_ack=1, pc_ld=1 (pc_src=0) and the FSM goes to FETCH.
REQ-019 The WAIT timeout SHALL be 15 consecutive WAIT cycles with dm_ack=0; the FSM SHALL then drop dm_we, set err=1 and enter HALT without pc_ld.
REQ-020 HLT in EXEC SHALL go to HALT with no pc_ld; HALT SHALL hold halted=1 and all strobes at 0 until reset.
REQ-021 ld_ac, pc_ld and dm_we SHALL be 0 in every state and case not named above; ac_src and pc_src SHALL be 0 whenever their strobes are 0.
REQ-022 instr_count SHALL increment by 1 on each cycle with pc_ld=1 and on entry to HALT via HLT, and SHALL wrap from 8'hFF to 8'h00.

Reset
REQ-023 reset=0 at a rising edge SHALL force FETCH, opq=0, instr_count=0, err=0, halted=0 and all strobes to 0, from any state, including WAIT mid-store and HALT.
REQ-024 No output SHALL change between rising edges; reset SHALL take priority over every transition.

Configuration
REQ-025 Macro SINGLE_STEP_EN SHALL control single-step mode.
REQ-026 With SINGLE_STEP_EN defined, FETCH SHALL hold until step is sampled 0 then 1 on consecutive edges (one instruction per rising edge of step); without the macro, step SHALL be ignored and FETCH SHALL always advance.

Verification
REQ-027 Reset then program LDA, ADD, JMP 0 -> ld_ac pulses at cycles 3 and 6; pc_ld with pc_src=1 at cycle 9; instr_count=3 after cycle 9.
REQ-028 JZ with ac_zero=1, then JZ with ac_zero=0 -> pc_src=1, then pc_src=0; pc_ld asserted in both EXEC cycles.
REQ-029 STA with dm_ack delayed 4 cycles -> dm_we high 5 cycles; pc_ld in the ack cycle; no ld_ac.
REQ-030 STA with dm_ack held 0 -> after 15 WAIT cycles: err=1, halted=1, dm_we=0, state=3'd4.
REQ-031 256 NOPs from reset -> instr_count wraps to 8'h00; HLT then freezes instr_count at 8'h01; reset asserted during WAIT -> all outputs 0 on the next edge.
REQ-032 With SINGLE_STEP_EN: step held 0 -> FSM stays in FETCH indefinitely; one 0->1 step edge -> exactly one instruction retires.
